// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the OTTER pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle. The master is the datapath, the slave the controller.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  import pipe_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]            ResultSrcE;
  logic                  PCSrcE, RegWriteM, RegWriteW;

  // Memory handshake: MemReqOut is held high from the first request cycle until the
  // cycle MemAckM is seen (or the wait times out); the access completes on that edge.
  logic                  MemReqM, MemAckM, MemReqOut, MemErr;

  fwd_sel_t              ForwardAE, ForwardBE;
  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE, FlushW;
  logic [31:0]           PerfLuCnt, PerfMemCnt;
  mem_state_t            mem_state_dbg;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemReqOut, MemErr, PerfLuCnt, PerfMemCnt,
           mem_state_dbg
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, MemAckM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemReqOut, MemErr, PerfLuCnt, PerfMemCnt,
           mem_state_dbg
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Forwarding select for one E-stage ALU operand; the M-stage result wins over W.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_w,
  input  logic [REG_ADDR_W-1:0] rd_w,
  output fwd_sel_t              fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage OTTER core: forwarding, load-use, branch
// flush and data-memory wait FSM. Stall-cycle counters are built only with HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int REG_ADDR_W  = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             mem_stall, lw_stall, mem_req_out;
  fwd_sel_t         fwd_a, fwd_b;

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_e        (hz.Rs1E),
    .reg_write_m (hz.RegWriteM),
    .rd_m        (hz.RdM),
    .reg_write_w (hz.RegWriteW),
    .rd_w        (hz.RdW),
    .fwd_sel     (fwd_a)
  );

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_e        (hz.Rs2E),
    .reg_write_m (hz.RegWriteM),
    .rd_m        (hz.RdM),
    .reg_write_w (hz.RegWriteW),
    .rd_w        (hz.RdW),
    .fwd_sel     (fwd_b)
  );

  assign lw_stall = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != '0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= MEM_IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // The timeout cycle itself releases the pipeline; the error pulse follows one cycle later.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_err_d   = 1'b0;
    mem_stall   = 1'b0;
    mem_req_out = hz.MemReqM;
    case (state_q)
      MEM_IDLE: begin
        if (hz.MemReqM && !hz.MemAckM) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          cnt_d     = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        mem_req_out = 1'b1;
        if (hz.MemAckM) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = MEM_IDLE;
          cnt_d     = '0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_stall = 1'b1;
        end
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  fwd_sel_t fwd_a_o, fwd_b_o;
  logic mem_req_o;

  // A memory wait freezes everything and drops E/D flushes; the held E stage re-raises them.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    fwd_a_o   = fwd_a;
    fwd_b_o   = fwd_b;
    mem_req_o = mem_req_out;
    if (!RST_N) begin
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      flush_w   = 1'b1;
      fwd_a_o   = FWD_RF;
      fwd_b_o   = FWD_RF;
      mem_req_o = 1'b0;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = lw_stall;
      stall_d = lw_stall;
      flush_e = lw_stall || hz.PCSrcE;
      flush_d = hz.PCSrcE;
    end
  end

  assign hz.StallF        = stall_f;
  assign hz.StallD        = stall_d;
  assign hz.StallE        = stall_e;
  assign hz.StallM        = stall_m;
  assign hz.FlushD        = flush_d;
  assign hz.FlushE        = flush_e;
  assign hz.FlushW        = flush_w;
  assign hz.ForwardAE     = fwd_a_o;
  assign hz.ForwardBE     = fwd_b_o;
  assign hz.MemReqOut     = mem_req_o;
  assign hz.MemErr        = mem_err_q;
  assign hz.mem_state_dbg = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_lu_d, perf_mem_q, perf_mem_d;

  always_comb begin
    perf_lu_d  = perf_lu_q;
    perf_mem_d = perf_mem_q;
    if (lw_stall && !mem_stall && (perf_lu_q != 32'hFFFF_FFFF)) begin
      perf_lu_d = perf_lu_q + 32'd1;
    end
    if (mem_stall && (perf_mem_q != 32'hFFFF_FFFF)) begin
      perf_mem_d = perf_mem_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_lu_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      perf_lu_q  <= perf_lu_d;
      perf_mem_q <= perf_mem_d;
    end
  end

  assign hz.PerfLuCnt  = perf_lu_q;
  assign hz.PerfMemCnt = perf_mem_q;
`else
  assign hz.PerfLuCnt  = 32'd0;
  assign hz.PerfMemCnt = 32'd0;
`endif

endmodule
